// File: rtl/xnor_match_pkg.sv
// Shared definitions for the serial XNOR word-compare sequencer.
package xnor_match_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/xnor_cell.sv
// One-bit equality cell shared by the sequencer; purely combinational.
module xnor_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a ^ b);

endmodule

// File: rtl/xnor_match_seq.sv
// Serial word compare: steps operand bit pairs LSB first through one XNOR cell
// and reports the number of equal positions over a start/busy/done handshake.
module xnor_match_seq
    import xnor_match_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             all_eq_o
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               all_eq_q, all_eq_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               a_bit, b_bit, bit_eq, last_bit;
    logic [CNT_W-1:0]   acc_sum;

    // Bit-select mux written as a compare loop so it stays width-clean at WIDTH=1.
    always_comb begin
        a_bit = 1'b0;
        b_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_bit = a_q[i];
                b_bit = b_q[i];
            end
        end
    end

    xnor_cell u_xnor_cell (
        .a (a_bit),
        .b (b_bit),
        .y (bit_eq)
    );

    assign acc_sum  = acc_q + CNT_W'(bit_eq);
    assign last_bit = (idx_q == IDX_W'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        match_cnt_d = match_cnt_q;
        all_eq_d    = all_eq_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over the final-bit transition; published results are untouched.
                if (abort_i) begin
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_sum;
                    if (last_bit) begin
                        match_cnt_d = acc_sum;
                        all_eq_d    = (acc_sum == CNT_W'(WIDTH));
                        state_d     = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            match_cnt_q <= '0;
            all_eq_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            match_cnt_q <= match_cnt_d;
            all_eq_q    <= all_eq_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign match_cnt_o = match_cnt_q;
    assign all_eq_o    = all_eq_q;

endmodule

// File: tb/tb_xnor_match_seq.sv
// Scoreboard bench for xnor_match_seq at WIDTH=8 and WIDTH=1.
module tb_xnor_match_seq;

    typedef struct packed {
        int   cnt;
        logic eq;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, abort8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, eq8;
    logic [3:0] cnt8;

    logic       start1 = 1'b0, abort1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, eq1;
    logic [0:0] cnt1;

    exp_t sb8[$];
    exp_t sb1[$];
    int   n_checks = 0;
    int   n_fail = 0;

    xnor_match_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start8), .abort_i(abort8),
        .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8),
        .match_cnt_o(cnt8), .all_eq_o(eq8)
    );

    xnor_match_seq #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1),
        .a_i(a1), .b_i(b1), .busy_o(busy1), .done_o(done1),
        .match_cnt_o(cnt1), .all_eq_o(eq1)
    );

    function automatic int model_cnt(input logic [63:0] a, input logic [63:0] b, input int w);
        int c = 0;
        for (int i = 0; i < w; i++) if (a[i] == b[i]) c++;
        return c;
    endfunction

    // Cycle k is the interval after edge k-1; edge 0 accepts the start.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit expect_result,
                        input int abort_cyc, input int glitch_cyc, input int busy_until,
                        output int done_cyc, output int n_done);
        exp_t e;
        done_cyc = 0;
        n_done   = 0;
        if (expect_result) begin
            e.cnt = model_cnt(64'(a), 64'(b), 8);
            e.eq  = (e.cnt == 8);
            sb8.push_back(e);
        end
        @(posedge clk); #1;
        a8 = a; b8 = b; start8 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            start8 = (k == glitch_cyc);
            abort8 = (k == abort_cyc);
            if (k == glitch_cyc) begin
                a8 = 8'h00; b8 = 8'hFF;
            end else if (k == 1) begin
                a8 = ~a; b8 = b ^ 8'h5A;
            end
            @(negedge clk);
            n_checks++;
            if (busy8 !== (k <= busy_until)) begin
                n_fail++;
                $display("FAIL busy_cycle%0d got %b want %b", k, busy8, (k <= busy_until));
            end
            if (done8 === 1'b1) begin
                n_done++;
                if (done_cyc == 0) done_cyc = k;
                n_checks++;
                if (sb8.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done cycle %0d got done_o=1 want 0", k);
                end else begin
                    e = sb8.pop_front();
                    if (cnt8 !== 4'(e.cnt) || eq8 !== e.eq) begin
                        n_fail++;
                        $display("FAIL result a=%h b=%h got cnt=%0d eq=%b want cnt=%0d eq=%b",
                                 a, b, cnt8, eq8, e.cnt, e.eq);
                    end
                    $display("txn w8 a=%h b=%h cnt=%0d all_eq=%b done_cycle=%0d", a, b, cnt8, eq8, k);
                end
            end
        end
    endtask

    task automatic check_done(input string name, input int done_cyc, input int n_done,
                              input int want_cyc, input int want_n);
        n_checks++;
        if (done_cyc != want_cyc || n_done != want_n) begin
            n_fail++;
            $display("FAIL %s done_cycle/count got %0d/%0d want %0d/%0d",
                     name, done_cyc, n_done, want_cyc, want_n);
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || cnt8 !== 4'd0 || eq8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_w8 got busy=%b done=%b cnt=%0d eq=%b want 0 0 0 0", busy8, done8, cnt8, eq8);
        end
        n_checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || cnt1 !== 1'b0 || eq1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_w1 got busy=%b done=%b cnt=%0d eq=%b want 0 0 0 0", busy1, done1, cnt1, eq1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_all_equal();
        int dc, nd;
        run8(8'h00, 8'h00, 1'b1, 0, 0, 9, dc, nd);
        check_done("all_equal", dc, nd, 9, 1);
    endtask

    task automatic test_patterns();
        int dc, nd;
        run8(8'hFF, 8'h00, 1'b1, 0, 0, 9, dc, nd);
        check_done("pattern_ff_00", dc, nd, 9, 1);
        run8(8'hA5, 8'hA4, 1'b1, 0, 0, 9, dc, nd);
        check_done("pattern_a5_a4", dc, nd, 9, 1);
    endtask

    task automatic test_abort();
        int dc, nd;
        run8(8'h0F, 8'h0F, 1'b0, 3, 0, 3, dc, nd);
        check_done("abort", dc, nd, 0, 0);
        n_checks++;
        if (cnt8 !== 4'd7 || eq8 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_hold got cnt=%0d eq=%b want cnt=7 eq=0", cnt8, eq8);
        end
    endtask

    task automatic test_back_to_back();
        int dc, nd;
        run8(8'h33, 8'h0F, 1'b1, 0, 4, 9, dc, nd);
        check_done("start_while_busy", dc, nd, 9, 1);
    endtask

    task automatic test_reset_midrun();
        int dc, nd;
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            start8 = 1'b0;
        end
        n_checks++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_busy got %b want 1", busy8);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || cnt8 !== 4'd0 || eq8 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset got busy=%b done=%b cnt=%0d eq=%b want 0 0 0 0", busy8, done8, cnt8, eq8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'h3C, 8'h3C, 1'b1, 0, 0, 9, dc, nd);
        check_done("after_reset", dc, nd, 9, 1);
    endtask

    task automatic test_width1();
        exp_t e;
        int   dc, nd;
        for (int v = 0; v < 4; v++) begin
            logic [1:0] ab;
            ab = 2'(v);
            e.cnt = model_cnt(64'(ab[1]), 64'(ab[0]), 1);
            e.eq  = (e.cnt == 1);
            sb1.push_back(e);
            dc = 0;
            nd = 0;
            @(posedge clk); #1;
            a1 = ab[1]; b1 = ab[0]; start1 = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                @(posedge clk); #1;
                start1 = 1'b0;
                a1 = ~a1;
                @(negedge clk);
                if (done1 === 1'b1) begin
                    nd++;
                    if (dc == 0) dc = k;
                    n_checks++;
                    if (sb1.size() == 0) begin
                        n_fail++;
                        $display("FAIL w1_unexpected_done cycle %0d got done_o=1 want 0", k);
                    end else begin
                        e = sb1.pop_front();
                        if (cnt1 !== 1'(e.cnt) || eq1 !== e.eq) begin
                            n_fail++;
                            $display("FAIL w1_result a=%b b=%b got cnt=%0d eq=%b want cnt=%0d eq=%b",
                                     ab[1], ab[0], cnt1, eq1, e.cnt, e.eq);
                        end
                        $display("txn w1 a=%b b=%b cnt=%0d all_eq=%b done_cycle=%0d", ab[1], ab[0], cnt1, eq1, k);
                    end
                end
            end
            check_done("width1", dc, nd, 2, 1);
        end
    endtask

    initial begin
        test_reset();
        test_all_equal();
        test_patterns();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        test_width1();
        n_checks++;
        if (sb8.size() != 0 || sb1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0", sb8.size(), sb1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
